max_scan_ctrl: RTL

- Sequential maximum-finder built around an N-bit unsigned "greater than" comparator.
- Accepts a run-length, streams that many operands through a valid/ready input, and keeps a running maximum and its index.
- Presents the result on a valid/ready output.
- Sits between a producer (memory reader or testbench stream) and any consumer needing max/argmax of a block of values.

---
 rtl/max_scan_ctrl_pkg.sv | 12 +
 rtl/max_scan_ctrl_if.sv | 44 ++++
 rtl/max_scan_ctrl_gt_cmp.sv | 13 +
 rtl/max_scan_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/max_scan_ctrl_pkg.sv
// Shared definitions for the max_scan_ctrl block: controller state encoding.
package max_scan_ctrl_pkg;

    // Controller states. The encoding is visible on the debug port so that
    // external checkers can follow the controller.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage : max_scan_ctrl_pkg

// File: rtl/max_scan_ctrl_if.sv
// Bus bundle for max_scan_ctrl: run control, operand stream and result port.
//
// Handshake rules, for both the operand and the result channel:
//   - A transfer happens on a rising clk edge where valid && ready are both 1.
//   - The source holds valid and its payload steady until the transfer.
//   - ready may be asserted independently of valid. ready never waits for valid.
//   - in_ready is high for every cycle the block is scanning.
//   - out_valid is high for every cycle a result is pending. out_max, out_idx
//     and out_empty stay stable while it waits.
interface max_scan_ctrl_if #(
    parameter int N  = 8,
    parameter int CW = 4
) ();

    // Run control
    logic          start;
    logic [CW-1:0] len;
    logic          busy;

    // Operand stream
    logic          in_valid;
    logic [N-1:0]  in_data;
    logic          in_ready;

    // Result
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_max;
    logic [CW-1:0] out_idx;
    logic          out_empty;

    // Producer/consumer side: drives requests, operands and result acceptance.
    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  busy, in_ready, out_valid, out_max, out_idx, out_empty
    );

    // Block side: the max-scan controller itself.
    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output busy, in_ready, out_valid, out_max, out_idx, out_empty
    );

endinterface : max_scan_ctrl_if

// File: rtl/max_scan_ctrl_gt_cmp.sv
// Unsigned N-bit "greater than" comparator: gt = (a > b).
module gt_cmp #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         gt
);

    // Both operands are plain unsigned vectors, so no sign extension is applied.
    assign gt = (a > b);

endmodule : gt_cmp

// File: rtl/max_scan_ctrl.sv
// Sequential max/argmax finder. It takes a run length, accepts that many
// operands over a valid/ready stream, and presents the maximum and the index
// of its first occurrence over a valid/ready result port.
module max_scan_ctrl
    import max_scan_ctrl_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    max_scan_ctrl_if.slave bus,
    output state_t         dbg_state
);

    state_t        state;
    logic [CW-1:0] len_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] idx_q;
    logic [N-1:0]  max_q;
    logic          empty_q;

    logic          in_gt;
    logic          xfer;
    logic          first;
    logic          last;

    // The incoming operand is compared against the running maximum.
    gt_cmp #(.N(N)) u_gt_cmp (
        .a  (bus.in_data),
        .b  (max_q),
        .gt (in_gt)
    );

    // Decode the operand transfer and its position in the run.
    // len_q is never 0 while scanning, so len_q-1 does not underflow.
    // count_q stays at or below len_q-1, so it never wraps.
    assign xfer  = (state == ST_SCAN) && bus.in_valid;
    assign first = (count_q == '0);
    assign last  = (count_q == (len_q - CW'(1)));

    // Controller state and datapath registers. All of them are cleared
    // asynchronously, so a run interrupted by reset leaves no result behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            len_q   <= '0;
            count_q <= '0;
            idx_q   <= '0;
            max_q   <= '0;
            empty_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        empty_q <= (bus.len == '0);
                        if (bus.len != '0) begin
                            len_q   <= bus.len;
                            count_q <= '0;
                            state   <= ST_SCAN;
                        end else begin
                            // An empty run reports a zero result straight away.
                            max_q <= '0;
                            idx_q <= '0;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_SCAN: begin
                    if (xfer) begin
                        // The first operand always seeds the maximum. After that only a
                        // strictly larger value replaces it, so ties keep the earlier index.
                        if (first || in_gt) begin
                            max_q <= bus.in_data;
                            idx_q <= count_q;
                        end
                        count_q <= count_q + CW'(1);
                        if (last) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status and handshake outputs are decoded from the state register.
    assign bus.busy      = (state != ST_IDLE);
    assign bus.in_ready  = (state == ST_SCAN);
    assign bus.out_valid = (state == ST_DONE);

    // Result registers hold their value in IDLE until a new run replaces them.
    assign bus.out_max   = max_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_empty = empty_q;

    assign dbg_state     = state;

endmodule : max_scan_ctrl
